// File: rtl/bootram_ctrl.sv
// Boot RAM controller: bridges the picorv32 native bus and a byte-serial loader onto four 2Kx8 RAM lanes.
// Optional running loader checksum on prog_sum when BOOTRAM_CTRL_CHECKSUM_EN is defined.
module bootram_ctrl #(
    parameter int ADDR_W = 11,
    parameter int CPU_RO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_sel,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    input  logic              prog_mode,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic [7:0]        prog_data,
    output logic              prog_ready,
    output logic              prog_full,
    output logic [ADDR_W+2:0] prog_count,
    output logic [7:0]        prog_sum,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic [3:0]        ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam int CW = ADDR_W + 3;
    localparam logic [CW-1:0] FULL_COUNT = CW'(1) << (ADDR_W + 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_CPU_RSP = 2'd2,
        ST_PRG_WR  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              ram_ce_q, ram_ce_d;
    logic [3:0]        ram_wre_q, ram_wre_d;
    logic [ADDR_W-1:0] ram_ad_q, ram_ad_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic              mem_ready_q, mem_ready_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [CW-1:0]     prog_count_q, prog_count_d;
    logic              prog_full_s;
    logic              prog_ready_s;
    logic              cpu_req_s;
    logic              byte_acc_s;
    logic              unused_s;
`ifdef BOOTRAM_CTRL_CHECKSUM_EN
    logic [7:0]        prog_sum_q, prog_sum_d;
`endif

    assign unused_s     = &{1'b0, mem_addr[31:ADDR_W+2], mem_addr[1:0]};
    assign prog_full_s  = (prog_count_q == FULL_COUNT);
    // mem_ready gating keeps the CPU's ready-sampling cycle from looking like a fresh request
    assign cpu_req_s    = mem_valid & mem_sel & ~mem_ready_q & ~prog_mode;
    assign prog_ready_s = prog_mode & (state_q == ST_IDLE) & ~prog_full_s & ~mem_ready_q;
    assign byte_acc_s   = prog_valid & prog_ready_s & ~prog_start;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        ram_ce_d     = 1'b0;
        ram_wre_d    = 4'b0000;
        ram_ad_d     = ram_ad_q;
        ram_din_d    = ram_din_q;
        mem_ready_d  = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        prog_count_d = prog_count_q;
`ifdef BOOTRAM_CTRL_CHECKSUM_EN
        prog_sum_d   = prog_sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (prog_start) begin
                    prog_count_d = '0;
`ifdef BOOTRAM_CTRL_CHECKSUM_EN
                    prog_sum_d   = 8'h00;
`endif
                end else begin
                    prog_count_d = prog_count_q;
                end
                if (cpu_req_s) begin
                    ram_ad_d  = mem_addr[ADDR_W+1:2];
                    ram_ce_d  = 1'b1;
                    ram_wre_d = (CPU_RO != 0) ? 4'b0000 : mem_wstrb;
                    ram_din_d = mem_wdata;
                    state_d   = ST_CPU_ACC;
                end else if (byte_acc_s) begin
                    ram_ad_d     = prog_count_q[ADDR_W+1:2];
                    ram_din_d    = {4{prog_data}};
                    ram_ce_d     = 1'b1;
                    ram_wre_d    = 4'b0001 << prog_count_q[1:0];
                    prog_count_d = prog_count_q + CW'(1);
`ifdef BOOTRAM_CTRL_CHECKSUM_EN
                    prog_sum_d   = prog_sum_q + prog_data;
`endif
                    state_d      = ST_PRG_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CPU_ACC: state_d = ST_CPU_RSP;
            ST_CPU_RSP: begin
                mem_rdata_d = ram_dout;
                mem_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_PRG_WR:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ram_ce_q     <= 1'b0;
            ram_wre_q    <= 4'b0000;
            ram_ad_q     <= '0;
            ram_din_q    <= 32'h0000_0000;
            mem_ready_q  <= 1'b0;
            mem_rdata_q  <= 32'h0000_0000;
            prog_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ram_ce_q     <= ram_ce_d;
            ram_wre_q    <= ram_wre_d;
            ram_ad_q     <= ram_ad_d;
            ram_din_q    <= ram_din_d;
            mem_ready_q  <= mem_ready_d;
            mem_rdata_q  <= mem_rdata_d;
            prog_count_q <= prog_count_d;
        end
    end

`ifdef BOOTRAM_CTRL_CHECKSUM_EN
    // Loader checksum register
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_sum_q <= 8'h00;
        end else begin
            prog_sum_q <= prog_sum_d;
        end
    end
    assign prog_sum = prog_sum_q;
`else
    assign prog_sum = 8'h00;
`endif

    assign mem_ready  = mem_ready_q;
    assign mem_rdata  = mem_rdata_q;
    assign prog_ready = prog_ready_s;
    assign prog_full  = prog_full_s;
    assign prog_count = prog_count_q;
    assign ram_ce     = ram_ce_q;
    assign ram_oce    = 1'b1;
    assign ram_wre    = ram_wre_q;
    assign ram_ad     = ram_ad_q;
    assign ram_din    = ram_din_q;

endmodule

// File: tb/tb_bootram_ctrl.sv
// Directed bench for bootram_ctrl with a four-lane RAM model (latency 1) and a CPU_RO=1 companion instance.
module tb_bootram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_sel;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        prog_mode, prog_start, prog_valid;
    logic [7:0]  prog_data;

    logic        mem_ready, prog_ready, prog_full, ram_ce, ram_oce;
    logic [31:0] mem_rdata, ram_din, ram_dout;
    logic [13:0] prog_count;
    logic [7:0]  prog_sum;
    logic [3:0]  ram_wre;
    logic [10:0] ram_ad;

    logic        ro_mem_ready, ro_prog_ready, ro_prog_full, ro_ram_ce, ro_ram_oce;
    logic [31:0] ro_mem_rdata, ro_ram_din;
    logic [13:0] ro_prog_count;
    logic [7:0]  ro_prog_sum;
    logic [3:0]  ro_ram_wre;
    logic [10:0] ro_ram_ad;
    logic [31:0] ro_ram_dout;

    logic [31:0] ram_m [0:2047];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses;
    logic [7:0]  exp_sum;

    always #5 clk = ~clk;

    bootram_ctrl dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .prog_mode(prog_mode),
        .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(prog_ready), .prog_full(prog_full), .prog_count(prog_count),
        .prog_sum(prog_sum), .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
        .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    bootram_ctrl #(.CPU_RO(1)) dut_ro (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(ro_mem_ready), .mem_rdata(ro_mem_rdata), .prog_mode(prog_mode),
        .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(ro_prog_ready), .prog_full(ro_prog_full), .prog_count(ro_prog_count),
        .prog_sum(ro_prog_sum), .ram_ce(ro_ram_ce), .ram_oce(ro_ram_oce), .ram_wre(ro_ram_wre),
        .ram_ad(ro_ram_ad), .ram_din(ro_ram_din), .ram_dout(ro_ram_dout)
    );

    assign ro_ram_dout = 32'h0000_0000;

    // Byte-lane RAM model: controls sampled at the edge, dout valid the following cycle
    always @(posedge clk) begin
        if (ram_ce) begin
            for (int n = 0; n < 4; n++) begin
                if (ram_wre[n]) ram_m[ram_ad][8*n +: 8] <= ram_din[8*n +: 8];
            end
            ram_dout <= ram_m[ram_ad];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        prog_valid = 1'b1;
        prog_data  = b;
        while (prog_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("byte_ready_timeout", {31'd0, prog_ready}, 32'd1);
        step();
        prog_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) ram_m[i] = 32'h0000_0000;
        ram_m[4] = 32'h1234_5678;
        ram_dout   = 32'h0000_0000;
        reset      = 1'b1;
        mem_valid  = 1'b0; mem_sel = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
        prog_mode  = 1'b0; prog_start = 1'b0; prog_valid = 1'b0; prog_data = 8'd0;
        step(); step();

        // reset values
        reset = 1'b0;
        check("rst_ram_ce",    {31'd0, ram_ce}, 32'd0);
        check("rst_ram_wre",   {28'd0, ram_wre}, 32'd0);
        check("rst_ram_ad",    {21'd0, ram_ad}, 32'd0);
        check("rst_ram_din",   ram_din, 32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_prog_cnt",  {18'd0, prog_count}, 32'd0);
        check("rst_prog_full", {31'd0, prog_full}, 32'd0);
        check("rst_prog_sum",  {24'd0, prog_sum}, 32'd0);
        check("rst_ram_oce",   {31'd0, ram_oce}, 32'd1);

        // reset in the middle of a CPU access
        mem_valid = 1'b1; mem_sel = 1'b1; mem_addr = 32'd0;
        step();
        check("abort_ce_set", {31'd0, ram_ce}, 32'd1);
        reset = 1'b1; mem_valid = 1'b0;
        step();
        check("abort_ce_clr", {31'd0, ram_ce}, 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_ready) pulses++;
        end
        check("abort_no_ready", pulses, 32'd0);

        // loader: five bytes
        prog_mode = 1'b1; prog_start = 1'b1;
        step();
        prog_start = 1'b0;
        send_byte(8'h11);
        check("prg_b0_wre", {28'd0, ram_wre}, 32'h1);
        send_byte(8'h22);
        check("prg_b1_wre", {28'd0, ram_wre}, 32'h2);
        check("prg_b1_din", ram_din, 32'h2222_2222);
        send_byte(8'h33);
        send_byte(8'h44);
        check("prg_b3_wre", {28'd0, ram_wre}, 32'h8);
        send_byte(8'h55);
        check("prg_b4_ad", {21'd0, ram_ad}, 32'd1);
        step(); step();
`ifdef BOOTRAM_CTRL_CHECKSUM_EN
        exp_sum = 8'hFF;
`else
        exp_sum = 8'h00;
`endif
        check("prg_count5", {18'd0, prog_count}, 32'd5);
        check("prg_sum",    {24'd0, prog_sum}, {24'd0, exp_sum});
        check("prg_word0",  ram_m[0], 32'h4433_2211);
        check("prg_word1",  ram_m[1], 32'h0000_0055);

        // CPU read of word 1, two-edge latency
        prog_mode = 1'b0;
        mem_valid = 1'b1; mem_sel = 1'b1; mem_addr = 32'h0000_0004; mem_wstrb = 4'd0;
        step();
        check("rd_lat_e0", {31'd0, mem_ready}, 32'd0);
        step();
        check("rd_lat_e1", {31'd0, mem_ready}, 32'd0);
        step();
        check("rd_lat_e2", {31'd0, mem_ready}, 32'd1);
        check("rd_data",   mem_rdata, 32'h0000_0055);
        mem_valid = 1'b0;
        step();
        check("rd_ready_drop", {31'd0, mem_ready}, 32'd0);

        // read with mem_valid held one cycle past ready
        mem_valid = 1'b1; mem_addr = 32'h0000_0000;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (mem_ready) pulses++;
            if (i == 3) check("hold_rd_data", mem_rdata, 32'h4433_2211);
            if (i == 4) mem_valid = 1'b0;
        end
        check("hold_one_pulse", pulses, 32'd1);

        // partial write to word 4
        mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wdata = 32'hAABB_CCDD; mem_wstrb = 4'b0110;
        step();
        check("wr_wre",    {28'd0, ram_wre}, 32'h6);
        check("ro_wr_wre", {28'd0, ro_ram_wre}, 32'h0);
        check("ro_wr_ce",  {31'd0, ro_ram_ce}, 32'd1);
        step(); step();
        check("wr_ready",    {31'd0, mem_ready}, 32'd1);
        check("ro_wr_ready", {31'd0, ro_mem_ready}, 32'd1);
        mem_valid = 1'b0; mem_wstrb = 4'd0;
        step();
        mem_valid = 1'b1;
        step(); step(); step();
        check("wr_rdback_rdy", {31'd0, mem_ready}, 32'd1);
        check("wr_rdback",     mem_rdata, 32'h12BB_CC78);
        mem_valid = 1'b0;
        step();

        // prog_start beats a same-cycle byte; then fill to full
        prog_mode = 1'b1; prog_start = 1'b1; prog_valid = 1'b1; prog_data = 8'h99;
        step();
        check("start_clr_cnt", {18'd0, prog_count}, 32'd0);
        check("start_no_ce",   {31'd0, ram_ce}, 32'd0);
        prog_start = 1'b0; prog_valid = 1'b0;
        for (int i = 0; i < 8192; i++) begin
            send_byte(8'(i));
        end
        step(); step();
        check("fill_count", {18'd0, prog_count}, 32'd8192);
        check("fill_full",  {31'd0, prog_full}, 32'd1);
        check("fill_ready", {31'd0, prog_ready}, 32'd0);
        check("fill_last",  ram_m[2047], 32'hFFFE_FDFC);
        prog_valid = 1'b1; prog_data = 8'hEE;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ram_ce) pulses++;
        end
        check("full_hold_ce",  pulses, 32'd0);
        check("full_hold_cnt", {18'd0, prog_count}, 32'd8192);
        prog_valid = 1'b0; prog_start = 1'b1;
        step();
        prog_start = 1'b0;
        check("restart_cnt",  {18'd0, prog_count}, 32'd0);
        check("restart_full", {31'd0, prog_full}, 32'd0);
        check("restart_rdy",  {31'd0, prog_ready}, 32'd1);

        // prog_mode rises one cycle after a CPU request
        prog_mode = 1'b0;
        mem_valid = 1'b1; mem_addr = 32'h0000_0000;
        step();
        prog_mode = 1'b1; prog_valid = 1'b1; prog_data = 8'h77;
        step();
        check("mix_rdy_acc", {31'd0, prog_ready}, 32'd0);
        step();
        check("mix_cpu_rdy",  {31'd0, mem_ready}, 32'd1);
        check("mix_cpu_data", mem_rdata, 32'h0302_0100);
        check("mix_rdy_rsp",  {31'd0, prog_ready}, 32'd0);
        mem_valid = 1'b0;
        step();
        check("mix_rdy_idle", {31'd0, prog_ready}, 32'd1);
        step();
        prog_valid = 1'b0;
        check("mix_byte_ce",  {31'd0, ram_ce}, 32'd1);
        check("mix_byte_wre", {28'd0, ram_wre}, 32'h1);
        check("mix_byte_din", ram_din, 32'h7777_7777);
        check("mix_byte_cnt", {18'd0, prog_count}, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
